fifo_uart_tx: RTL and testbench

- Reader/consumer end of the byte fifo. It drains the fifo one byte at a time using the fifo's `emptyB` / `read` / `rdata` interface.
- Each byte goes out on a single serial line as an 8N1 UART frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Sits between the fifo output and the board's serial TX pin.

---
 rtl/fifo_uart_tx_pkg.sv | 7 +
 rtl/fifo_uart_tx_bit_timer.sv | 21 ++
 rtl/fifo_uart_tx.sv | 74 +++++++
 tb/tb_fifo_uart_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: state encoding and 8N1 frame constants shared by the fifo UART transmitter.
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 counter; tick marks the last cycle of a bit period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the fifo and sends each as an 8N1 frame on txd.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               emptyB,
  input  logic [7:0]         rdata,
  output logic               read,
  output logic               txd,
  output logic               busy,
  output logic [COUNT_W-1:0] tx_count
);
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic tick;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == LOAD),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = (emptyB && enable) ? POP : IDLE;
      POP: state_d = LOAD;
      LOAD: begin
        shift_d = rdata;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    read = state_q == POP;
    busy = state_q != IDLE;
    txd = (state_q == START) ? START_LVL : (state_q == DATA) ? shift_q[0] : STOP_LVL;
    tx_count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of the fifo UART transmitter against a behavioural fifo source.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 0, reset = 1, enable = 0;
  logic [7:0] rdata = 0;
  logic read, txd, busy, emptyB;
  logic [7:0] tx_count;
  logic [7:0] mem [1024];
  int wr_ptr = 0, rd_ptr = 0, reads = 0, cyc = 0;
  int tests = 0, fails = 0;
  logic bad_pop = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .emptyB(emptyB), .rdata(rdata),
    .read(read), .txd(txd), .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  assign emptyB = wr_ptr != rd_ptr;

  // fifo source: data registered on the pop edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read) begin
      reads <= reads + 1;
      if (!emptyB) bad_pop <= 1'b1;
      else begin
        rdata <= mem[rd_ptr % 1024];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(output int t);
    int k = 0;
    t = -1;
    while (txd !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (txd !== 1'b0) check("start_timeout", 32'd0, 32'd1);
    else t = cyc;
  endtask

  task automatic rx(output logic [7:0] b, output int t);
    b = '0;
    wait_start(t);
    if (t < 0) return;
    cyc_n(CPB / 2);
    check("rx_start_bit", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc_n(CPB);
      b[i] = txd;
    end
    cyc_n(CPB);
    check("rx_stop_bit", {31'd0, txd}, 32'd1);
  endtask

  initial begin
    logic [7:0] b, v;
    int t0, t1, r0;
    cyc_n(3);
    reset = 0;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {24'd0, tx_count}, 32'd0);
    enable = 1;
    cyc_n(50);
    check("empty_no_read", reads, 32'd0);

    v = 8'h55;
    push(v);
    r0 = reads;
    cyc_n(1);
    check("pop_read_hi", {31'd0, read}, 32'd1);
    cyc_n(1);
    check("pop_read_lo", {31'd0, read}, 32'd0);
    cyc_n(1);
    for (int i = 0; i < 10 * CPB; i++) begin
      check("frame55_txd", {31'd0, txd},
            (i < CPB) ? 32'd0 : (i < 9 * CPB) ? {31'd0, v[(i - CPB) / CPB]} : 32'd1);
      cyc_n(1);
    end
    check("frame55_count", {24'd0, tx_count}, 32'd1);
    check("frame55_busy", {31'd0, busy}, 32'd0);
    check("frame55_empty", {31'd0, emptyB}, 32'd0);
    check("frame55_reads", reads - r0, 32'd1);

    r0 = reads;
    push(8'h48);
    push(8'h69);
    rx(b, t0);
    check("b2b_byte0", {24'd0, b}, 32'h48);
    rx(b, t1);
    check("b2b_byte1", {24'd0, b}, 32'h69);
    check("b2b_gap", t1 - t0, 32'd43);
    cyc_n(2);
    check("b2b_reads", reads - r0, 32'd2);
    check("b2b_count", {24'd0, tx_count}, 32'd3);

    enable = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    r0 = reads;
    cyc_n(100);
    check("dis_no_read", reads - r0, 32'd0);
    enable = 1;
    wait_start(t0);
    cyc_n(10);
    check("dis_busy_data", {31'd0, busy}, 32'd1);
    enable = 0;
    cyc_n(150);
    check("dis_one_read", reads - r0, 32'd1);
    check("dis_count", {24'd0, tx_count}, 32'd4);
    check("dis_empty", {31'd0, emptyB}, 32'd1);
    check("dis_left", wr_ptr - rd_ptr, 32'd2);
    enable = 1;
    rx(b, t0);
    check("dis_byte1", {24'd0, b}, 32'h22);
    rx(b, t0);
    check("dis_byte2", {24'd0, b}, 32'h33);
    cyc_n(2);
    check("dis_count2", {24'd0, tx_count}, 32'd6);

    push(8'hA3);
    wait_start(t0);
    cyc_n(CPB + 3 * CPB + 1);
    reset = 1;
    cyc_n(1);
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_read", {31'd0, read}, 32'd0);
    check("mid_rst_count", {24'd0, tx_count}, 32'd0);
    reset = 0;
    r0 = reads;
    cyc_n(50);
    check("post_rst_no_read", reads - r0, 32'd0);

    for (int i = 0; i < 257; i++) push(8'(i * 37 + 5));
    for (int i = 0; i < 257; i++) begin
      rx(b, t0);
      check("bulk_byte", {24'd0, b}, {24'd0, 8'(i * 37 + 5)});
    end
    cyc_n(2);
    check("bulk_count_wrap", {24'd0, tx_count}, 32'd1);
    check("bulk_empty", {31'd0, emptyB}, 32'd0);
    check("no_empty_pop", {31'd0, bad_pop}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
